// File: rtl/ddr_ser_altera_if.sv
// Word-input handshake bundle for the DDR serializer: the producer drives data/valid,
// the serializer answers with ready.
interface ddr_ser_altera_if #(
    parameter int DATA_W = 16
);
    logic [DATA_W-1:0] data_i;
    logic              valid_i;
    logic              ready_o;

    modport master (
        output data_i,
        output valid_i,
        input  ready_o
    );

    modport slave (
        input  data_i,
        input  valid_i,
        output ready_o
    );
endinterface

// File: rtl/ddr_ser_altera.sv
// Parallel-to-DDR serializer: one bit pair per clock with a one-word holding register.
// Optional build macro DDR_SER_LSB_FIRST_EN reverses the pair order (LSB pair first).
module ddr_ser_altera #(
    parameter int          DATA_W = 16,
    parameter logic [1:0]  IDLE   = 2'b00
) (
    input  logic              clk_i,
    input  logic              rst_i,
    ddr_ser_altera_if.slave   in_if,
    output logic [1:0]        ddr_o,
    output logic              frame_o,
    output logic              busy_o
);
    localparam int              P    = DATA_W / 2;
    localparam int              CW   = (P > 1) ? $clog2(P) : 1;
    localparam logic [CW-1:0]   LAST = CW'(P - 1);

    logic [DATA_W-1:0] sh;
    logic [DATA_W-1:0] hold;
    logic [DATA_W-1:0] sh_next;
    logic [CW-1:0]     cnt;
    logic              sh_vld;
    logic              hold_vld;
    logic              accept;
    logic              last_pair;
    logic              free;
    logic [1:0]        cur_pair;

    assign in_if.ready_o = !hold_vld;
    assign accept        = in_if.valid_i && !hold_vld;
    assign last_pair     = sh_vld && (cnt == LAST);
    assign free          = !sh_vld || last_pair;

`ifdef DDR_SER_LSB_FIRST_EN
    assign sh_next  = {2'b00, sh[DATA_W-1:2]};
    assign cur_pair = sh[1:0];
`else
    assign sh_next  = {sh[DATA_W-3:0], 2'b00};
    assign cur_pair = {sh[DATA_W-2], sh[DATA_W-1]};
`endif

    // A held word always wins the shifter over a fresh accept so ordering is preserved;
    // the fresh word only bypasses hold when hold is empty.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            sh       <= '0;
            hold     <= '0;
            cnt      <= '0;
            sh_vld   <= 1'b0;
            hold_vld <= 1'b0;
        end else if (free && hold_vld) begin
            sh       <= hold;
            cnt      <= '0;
            sh_vld   <= 1'b1;
            hold_vld <= accept;
            if (accept) begin
                hold <= in_if.data_i;
            end
        end else if (free && accept) begin
            sh     <= in_if.data_i;
            cnt    <= '0;
            sh_vld <= 1'b1;
        end else if (last_pair) begin
            sh_vld <= 1'b0;
        end else if (sh_vld) begin
            cnt <= cnt + 1'b1;
            sh  <= sh_next;
            if (accept) begin
                hold     <= in_if.data_i;
                hold_vld <= 1'b1;
            end
        end
    end

    assign ddr_o   = sh_vld ? cur_pair : IDLE;
    assign frame_o = sh_vld && (cnt == '0);
    assign busy_o  = sh_vld || hold_vld;
endmodule

// File: tb/tb_ddr_ser_altera.sv
// Scoreboard bench for ddr_ser_altera: accepted words are expanded into timestamped
// expected pairs, and every cycle the output is checked against the scoreboard front.
module tb_ddr_ser_altera;
    localparam int         DATA_W = 16;
    localparam int         P      = DATA_W / 2;
    localparam logic [1:0] IDLE   = 2'b10;

    typedef struct {
        int         stamp;
        logic [1:0] pair;
        logic       frame;
    } sb_t;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [1:0]  ddr_o;
    logic        frame_o;
    logic        busy_o;

    ddr_ser_altera_if #(.DATA_W(DATA_W)) bus ();

    ddr_ser_altera #(.DATA_W(DATA_W), .IDLE(IDLE)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .in_if   (bus),
        .ddr_o   (ddr_o),
        .frame_o (frame_o),
        .busy_o  (busy_o)
    );

    always #5 clk_i = ~clk_i;

    sb_t sb[$];
    int  frameLog[$];
    int  cyc         = 0;
    int  nextFree    = 0;
    int  lastStart   = -1;
    int  nCompared   = 0;
    int  nMismatched = 0;

    function automatic logic [1:0] exp_pair(input logic [DATA_W-1:0] w, input int k);
`ifdef DDR_SER_LSB_FIRST_EN
        return {w[2*k+1], w[2*k]};
`else
        return {w[DATA_W-2-2*k], w[DATA_W-1-2*k]};
`endif
    endfunction

    // Reference timing: a word starts on the edge it is accepted or right after the previous word.
    always @(posedge clk_i) begin
        int  start;
        sb_t e;
        cyc = cyc + 1;
        if (!rst_i) begin
            sb.delete();
            nextFree  = 0;
            lastStart = -1;
        end else if (bus.valid_i && bus.ready_o) begin
            start = (cyc > nextFree) ? cyc : nextFree;
            for (int k = 0; k < P; k++) begin
                e.stamp = start + k;
                e.pair  = exp_pair(bus.data_i, k);
                e.frame = (k == 0);
                sb.push_back(e);
            end
            nextFree  = start + P;
            lastStart = start;
        end
    end

    always @(negedge clk_i) begin
        logic [1:0] expDdr;
        logic       expFrame;
        logic       expBusy;
        logic       expReady;
        sb_t        e;
        if (cyc > 0) begin
            expBusy  = (sb.size() != 0);
            expReady = !(lastStart > cyc);
            expDdr   = IDLE;
            expFrame = 1'b0;
            if (sb.size() != 0 && sb[0].stamp == cyc) begin
                e        = sb.pop_front();
                expDdr   = e.pair;
                expFrame = e.frame;
            end
            if (frame_o === 1'b1) frameLog.push_back(cyc);
            nCompared += 4;
            if (ddr_o !== expDdr) begin
                nMismatched++;
                $display("[TB] FAIL ddr @%0d: got %b, want %b", cyc, ddr_o, expDdr);
            end
            if (frame_o !== expFrame) begin
                nMismatched++;
                $display("[TB] FAIL frame @%0d: got %b, want %b", cyc, frame_o, expFrame);
            end
            if (busy_o !== expBusy) begin
                nMismatched++;
                $display("[TB] FAIL busy @%0d: got %b, want %b", cyc, busy_o, expBusy);
            end
            if (bus.ready_o !== expReady) begin
                nMismatched++;
                $display("[TB] FAIL ready @%0d: got %b, want %b", cyc, bus.ready_o, expReady);
            end
        end
    end

    task automatic push_word(input logic [DATA_W-1:0] w, output int stalls);
        int k;
        stalls = 0;
        for (k = 0; k < 100; k++) begin
            @(negedge clk_i);
            bus.valid_i = 1'b1;
            if (bus.ready_o === 1'b1) begin
                bus.data_i = w;
                break;
            end
            bus.data_i = DATA_W'($urandom);
            stalls++;
        end
        nCompared++;
        if (k >= 100) begin
            nMismatched++;
            $display("[TB] FAIL accept_timeout: got %0d stall cycles, want < 100", k);
        end
    endtask

    task automatic go_idle();
        @(negedge clk_i);
        bus.valid_i = 1'b0;
        bus.data_i  = DATA_W'($urandom);
    endtask

    task automatic drain();
        int k = 0;
        while (sb.size() != 0 && k < 200) begin
            @(negedge clk_i);
            k++;
        end
        nCompared++;
        if (sb.size() != 0) begin
            nMismatched++;
            $display("[TB] FAIL drain_timeout: got %0d pending pairs, want 0", sb.size());
        end
        repeat (2) @(negedge clk_i);
    endtask

    task automatic test_reset();
        rst_i       = 1'b0;
        bus.valid_i = 1'b1;
        bus.data_i  = 16'hFFFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            nCompared += 3;
            if (ddr_o !== IDLE) begin
                nMismatched++;
                $display("[TB] FAIL reset_ddr: got %b, want %b", ddr_o, IDLE);
            end
            if (bus.ready_o !== 1'b1) begin
                nMismatched++;
                $display("[TB] FAIL reset_ready: got %b, want 1", bus.ready_o);
            end
            if (busy_o !== 1'b0) begin
                nMismatched++;
                $display("[TB] FAIL reset_busy: got %b, want 0", busy_o);
            end
        end
        bus.valid_i = 1'b0;
        rst_i       = 1'b1;
        repeat (2) @(negedge clk_i);
    endtask

    task automatic test_single_word();
        int stalls;
        frameLog.delete();
        push_word(16'hC35A, stalls);
        go_idle();
        drain();
        nCompared++;
        if (frameLog.size() !== 1) begin
            nMismatched++;
            $display("[TB] FAIL single_frames: got %0d, want 1", frameLog.size());
        end
    endtask

    task automatic test_back_to_back();
        int stalls;
        int total = 0;
        frameLog.delete();
        push_word(16'h0001, stalls); total += stalls;
        push_word(16'h8000, stalls); total += stalls;
        push_word(16'hFFFF, stalls); total += stalls;
        go_idle();
        drain();
        nCompared += 2;
        if (total == 0) begin
            nMismatched++;
            $display("[TB] FAIL b2b_ready_low: got 0 stall cycles, want > 0");
        end
        if (frameLog.size() !== 3) begin
            nMismatched++;
            $display("[TB] FAIL b2b_frames: got %0d, want 3", frameLog.size());
        end else begin
            nCompared += 2;
            if (frameLog[1] - frameLog[0] !== P) begin
                nMismatched++;
                $display("[TB] FAIL b2b_gap01: got %0d, want %0d", frameLog[1] - frameLog[0], P);
            end
            if (frameLog[2] - frameLog[1] !== P) begin
                nMismatched++;
                $display("[TB] FAIL b2b_gap12: got %0d, want %0d", frameLog[2] - frameLog[1], P);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [DATA_W-1:0] words [4] = '{16'h1234, 16'hABCD, 16'h0F0F, 16'h9669};
        int stalls;
        int total = 0;
        frameLog.delete();
        foreach (words[i]) begin
            push_word(words[i], stalls);
            total += stalls;
        end
        go_idle();
        drain();
        nCompared += 2;
        if (total < 2 * (P - 1)) begin
            nMismatched++;
            $display("[TB] FAIL bp_stalls: got %0d, want >= %0d", total, 2 * (P - 1));
        end
        if (frameLog.size() !== 4) begin
            nMismatched++;
            $display("[TB] FAIL bp_frames: got %0d, want 4", frameLog.size());
        end
    endtask

    task automatic test_midword_reset();
        int stalls;
        push_word(16'hAAAA, stalls);
        push_word(16'h5555, stalls);
        go_idle();
        repeat (2) @(negedge clk_i);
        nCompared++;
        if (bus.ready_o !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL mid_hold_full: got ready %b, want 0", bus.ready_o);
        end
        rst_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b1;
        nCompared += 2;
        if (ddr_o !== IDLE) begin
            nMismatched++;
            $display("[TB] FAIL mid_reset_ddr: got %b, want %b", ddr_o, IDLE);
        end
        if (busy_o !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL mid_reset_busy: got %b, want 0", busy_o);
        end
        repeat (12) @(negedge clk_i);
    endtask

    task automatic test_pair_order();
        int stalls;
        int k = 0;
        logic [1:0] want;
`ifdef DDR_SER_LSB_FIRST_EN
        want = 2'b01;
`else
        want = 2'b00;
`endif
        push_word(16'h0001, stalls);
        go_idle();
        while (frame_o !== 1'b1 && k < 20) begin
            @(negedge clk_i);
            k++;
        end
        nCompared++;
        if (frame_o !== 1'b1 || ddr_o !== want) begin
            nMismatched++;
            $display("[TB] FAIL order_pair0: got frame %b ddr %b, want frame 1 ddr %b", frame_o, ddr_o, want);
        end
        drain();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_i       = 1'b0;
        bus.valid_i = 1'b0;
        bus.data_i  = '0;
        test_reset();
        test_single_word();
        test_back_to_back();
        test_backpressure();
        test_midword_reset();
        test_pair_order();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end
endmodule
